iir_biquad_seq: RTL and testbench



---
 rtl/iir_biquad_seq_if.sv | 28 ++
 rtl/iir_biquad_seq.sv | 139 +++++++++++++
 tb/tb_iir_biquad_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_biquad_seq_if.sv
// Streaming and coefficient-programming bundle for iir_biquad_seq.
// master = sample source / controller side, slave = the filter itself.
interface iir_biquad_seq_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     coef_we;
  logic [2:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     clear_state;
  logic                     busy;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, clear_state,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, clear_state,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/iir_biquad_seq.sv
// Direct Form I biquad IIR, one shared MAC stepping through 5 taps per sample.
// Define IIR_SATURATE_EN to clamp the result instead of two's-complement wrap.
module iir_biquad_seq #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = DATA_W + COEF_W + 3
) (
  input  logic              clk,
  input  logic              reset,
  iir_biquad_seq_if.slave   bus
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int R_W    = ACC_W - FRAC_W;
  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4, S_FINAL, S_HOLD
  } state_e;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [DATA_W-1:0] data_t;

  state_e                   state_q, state_d;
  coef_t                    coef_sh_q  [5];
  coef_t                    coef_act_q [5];
  data_t                    x0_q, x1_q, x2_q, y1_q, y2_q, out_data_q;
  logic signed [ACC_W-1:0]  acc_q;

  coef_t                    tap_coef;
  data_t                    tap_opnd;
  logic                     tap_sub;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, acc_rnd;
  logic signed [R_W-1:0]    r_full;
  data_t                    y_res;
  logic                     unused_bits;

  // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_MAC0;
      S_MAC0:  state_d = S_MAC1;
      S_MAC1:  state_d = S_MAC2;
      S_MAC2:  state_d = S_MAC3;
      S_MAC3:  state_d = S_MAC4;
      S_MAC4:  state_d = S_FINAL;
      S_FINAL: state_d = S_HOLD;
      S_HOLD:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tap select: feed-forward taps add, feedback taps (a1, a2) subtract.
  always_comb begin
    tap_coef = coef_act_q[0];
    tap_opnd = x0_q;
    tap_sub  = 1'b0;
    case (state_q)
      S_MAC1: begin tap_coef = coef_act_q[1]; tap_opnd = x1_q; end
      S_MAC2: begin tap_coef = coef_act_q[2]; tap_opnd = x2_q; end
      S_MAC3: begin tap_coef = coef_act_q[3]; tap_opnd = y1_q; tap_sub = 1'b1; end
      S_MAC4: begin tap_coef = coef_act_q[4]; tap_opnd = y2_q; tap_sub = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = PROD_W'(tap_coef) * PROD_W'(tap_opnd);
  assign prod_ext = ACC_W'(prod);
  assign acc_rnd  = acc_q + RND;
  assign r_full   = acc_rnd[ACC_W-1:FRAC_W];

`ifdef IIR_SATURATE_EN
  always_comb begin
    y_res = r_full[DATA_W-1:0];
    if (!(&r_full[R_W-1:DATA_W-1]) && (|r_full[R_W-1:DATA_W-1]))
      y_res = r_full[R_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
  assign unused_bits = ^acc_rnd[FRAC_W-1:0];
`else
  assign y_res       = r_full[DATA_W-1:0];
  assign unused_bits = ^{acc_rnd[FRAC_W-1:0], r_full[R_W-1:DATA_W]};
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
      out_data_q <= '0;
      // NOTE: both coefficient banks are reset because a fresh filter must output zero until programmed.
      for (int i = 0; i < 5; i++) begin
        coef_sh_q[i]  <= '0;
        coef_act_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (bus.coef_we && (bus.coef_addr < 3'd5))
        coef_sh_q[bus.coef_addr] <= bus.coef_wdata;
      case (state_q)
        S_IDLE: begin
          if (bus.clear_state) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
          end
          if (bus.in_valid) begin
            x0_q  <= bus.in_data;
            acc_q <= '0;
            for (int i = 0; i < 5; i++) coef_act_q[i] <= coef_sh_q[i];
          end
        end
        S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4:
          acc_q <= tap_sub ? acc_q - prod_ext : acc_q + prod_ext;
        S_FINAL: begin
          out_data_q <= y_res;
          x2_q       <= x1_q;
          x1_q       <= x0_q;
          y2_q       <= y1_q;
          y1_q       <= y_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_iir_biquad_seq.sv
// Scoreboard bench for iir_biquad_seq: stimulus pushes hand-computed outputs,
// a monitor pops and compares on every output handshake.
module tb_iir_biquad_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  iir_biquad_seq_if bus ();

  iir_biquad_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each accepted output against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0d expected no output", bus.out_data);
      end else begin
        check("y", int'(bus.out_data), exp_q.pop_front());
      end
    end
  end

  task automatic wr_coef(input int addr, input int val);
    @(posedge clk); #1;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 3'(addr);
    bus.coef_wdata = 16'(val);
    @(posedge clk); #1;
    bus.coef_we    = 1'b0;
  endtask

  task automatic set_coefs(input int b0, input int b1, input int b2, input int a1, input int a2);
    wr_coef(0, b0);
    wr_coef(1, b1);
    wr_coef(2, b2);
    wr_coef(3, a1);
    wr_coef(4, a2);
    wr_coef(5, 32767);
    wr_coef(7, -1);
  endtask

  task automatic clear_hist();
    @(posedge clk); #1 bus.clear_state = 1'b1;
    @(posedge clk); #1 bus.clear_state = 1'b0;
  endtask

  // Offer one sample; returns 1 time unit after the accepting edge.
  task automatic send(input int x, input int exp, input bit push);
    int n = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(x);
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", int'(bus.in_ready), 1);
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;
    bus.coef_we     = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_wdata  = '0;
    bus.clear_state = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_busy", int'(bus.busy), 0);

    // Passthrough with latency and ready-return timing.
    set_coefs(16384, 0, 0, 0, 0);
    send(1000, 1000, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    check("latency", n - 1, 6);
    check("ready_low_in_hold", int'(bus.in_ready), 0);
    @(negedge clk);
    check("ready_after_hs", int'(bus.in_ready), 1);
    check("valid_after_hs", int'(bus.out_valid), 0);
    drain();

    // One-pole impulse response.
    set_coefs(8192, 0, 0, -8192, 0);
    clear_hist();
    send(1000, 500, 1'b1);
    send(0, 250, 1'b1);
    send(0, 125, 1'b1);
    send(0, 63, 1'b1);
    send(0, 32, 1'b1);
    send(0, 16, 1'b1);
    drain();

    // clear_state together with in_valid: clear wins (750 without it).
    clear_hist();
    send(1000, 500, 1'b1);
    drain();
    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.in_data     = 16'sd1000;
    bus.clear_state = 1'b1;
    exp_q.push_back(500);
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.clear_state = 1'b0;
    send(0, 250, 1'b1);
    drain();

    // Overflow: wrap by default, clamp with IIR_SATURATE_EN.
    set_coefs(32767, 0, 0, 0, 0);
`ifdef IIR_SATURATE_EN
    send(30000, 32767, 1'b1);
    send(-30000, -32768, 1'b1);
`else
    send(30000, -5538, 1'b1);
    send(-30000, 5538, 1'b1);
`endif
    drain();

    // Backpressure: stalled output must hold and block new samples.
    set_coefs(16384, 0, 0, 0, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'sd111;
    exp_q.push_back(111);
    exp_q.push_back(222);
    @(posedge clk); #1;
    bus.in_data = 16'sd222;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", int'(bus.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_data", int'(bus.out_data), 111);
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_ready_back", int'(bus.in_ready), 1);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    drain();

    // Shadow write during MAC2 affects only the next sample.
    clear_hist();
    send(1000, 1000, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    check("busy_in_mac", int'(bus.busy), 1);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 3'd0;
    bus.coef_wdata = 16'sd8192;
    @(posedge clk); #1 bus.coef_we = 1'b0;
    drain();
    send(1000, 500, 1'b1);
    drain();

    // Write and accept on the same edge: active bank takes the old value.
    set_coefs(16384, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("same_cycle_ready", int'(bus.in_ready), 1);
    bus.in_valid   = 1'b1;
    bus.in_data    = 16'sd1000;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 3'd0;
    bus.coef_wdata = 16'sd8192;
    exp_q.push_back(1000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    drain();
    send(1000, 500, 1'b1);
    drain();

    // Reset during MAC3 aborts the sample and zeroes the coefficients.
    send(500, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_ready", int'(bus.in_ready), 1);
    check("mid_rst_data", int'(bus.out_data), 0);
    send(1234, 0, 1'b1);
    drain();

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
